// File: rtl/decoded_mop_queue_pkg.sv
// decoded_mop_queue_pkg: shared sizes, index/count types and entry layout for the decoded micro-op queue
package decoded_mop_queue_pkg;
  localparam int MOP_IN_WIDTH = 4;
  localparam int MOP_OUT_WIDTH = 4;
  localparam int MOP_QUEUE_DEPTH = 16;
  typedef logic [$clog2(MOP_QUEUE_DEPTH)-1:0] mop_queue_index_t;
  typedef logic [$clog2(MOP_QUEUE_DEPTH+1)-1:0] mop_queue_count_t;
  typedef struct packed {
    logic [23:0] op_info;
    logic [31:0] pc;
    logic [1:0]  b_pred;
    logic [5:0]  op_id;
  } decoded_mop_entry_t;
  localparam int MOP_ENTRY_BITS = $bits(decoded_mop_entry_t);
  function automatic int imin(input int a, input int b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/decoded_mop_queue_if.sv
// decoded_mop_queue_if: decode-side enqueue and rename-side dequeue signals of the micro-op queue
interface decoded_mop_queue_if
  import decoded_mop_queue_pkg::*;
#(
  parameter int ENTRY_BITS = MOP_ENTRY_BITS,
  parameter int IN_WIDTH = MOP_IN_WIDTH,
  parameter int OUT_WIDTH = MOP_OUT_WIDTH,
  parameter int DEPTH = MOP_QUEUE_DEPTH
);
  logic [IN_WIDTH-1:0]                  enq_valid;
  logic [IN_WIDTH-1:0][ENTRY_BITS-1:0]  enq_data;
  logic                                 enq_stall;
  logic [OUT_WIDTH-1:0]                 deq_valid;
  logic [OUT_WIDTH-1:0][ENTRY_BITS-1:0] deq_data;
  logic                                 deq_accept;
  logic [$clog2(DEPTH+1)-1:0]           count;
  modport master (output enq_valid, enq_data, deq_accept, input enq_stall, deq_valid, deq_data, count);
  modport slave (input enq_valid, enq_data, deq_accept, output enq_stall, deq_valid, deq_data, count);
endinterface

// File: rtl/decoded_mop_queue_compactor.sv
// decoded_mop_queue_compactor: prefix count of valid lanes giving each lane its compacted offset and the total
module decoded_mop_queue_compactor
  import decoded_mop_queue_pkg::*;
#(
  parameter int W = MOP_IN_WIDTH,
  parameter int OW = $clog2(W+1)
) (
  input  logic [W-1:0]         valid,
  output logic [W-1:0][OW-1:0] off,
  output logic [OW-1:0]        n
);
  always_comb begin
    n = '0;
    for (int i = 0; i < W; i++) begin
      off[i] = n;
      n = n + OW'(valid[i]);
    end
  end
endmodule

// File: rtl/decoded_mop_queue.sv
// decoded_mop_queue: circular buffer between decode and rename with lane compaction and registered stall.
// RSD_MOP_QUEUE_BYPASS_EN enables a same-cycle path from enqueue lanes to dequeue lanes when empty.
module decoded_mop_queue
  import decoded_mop_queue_pkg::*;
#(
  parameter int ENTRY_BITS = MOP_ENTRY_BITS,
  parameter int IN_WIDTH = MOP_IN_WIDTH,
  parameter int OUT_WIDTH = MOP_OUT_WIDTH,
  parameter int DEPTH = MOP_QUEUE_DEPTH
) (
  input logic clk,
  input logic rst,
  input logic flush,
  decoded_mop_queue_if.slave q
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(IN_WIDTH+1);
  logic [ENTRY_BITS-1:0]          mem [DEPTH];
  logic [IW-1:0]                  head, tail;
  logic [CW-1:0]                  cnt, n_avail, n_deq, n_wr;
  logic [IN_WIDTH-1:0][OW-1:0]    off;
  logic [OW-1:0]                  n_enq, n_byp;
  logic [IN_WIDTH-1:0][IW-1:0]    wr_idx;
  logic [IN_WIDTH-1:0]            wr_en;
  logic                           enq_fire, byp;
  decoded_mop_queue_compactor #(.W(IN_WIDTH), .OW(OW)) u_cmp (
    .valid(q.enq_valid),
    .off(off),
    .n(n_enq)
  );
  // stall looks only at registered occupancy so decode sees no input-to-stall path
  assign q.enq_stall = (DEPTH - int'(cnt)) < IN_WIDTH;
  assign q.count = cnt;
  assign enq_fire = !q.enq_stall && !flush;
  assign n_avail = CW'(imin(int'(cnt), OUT_WIDTH));
  assign n_deq = q.deq_accept && !flush ? n_avail : '0;
`ifdef RSD_MOP_QUEUE_BYPASS_EN
  assign byp = cnt == '0 && !flush && !rst;
`else
  assign byp = 1'b0;
`endif
  // lanes handed straight to rename are not stored; the rest close up behind tail
  assign n_byp = byp && q.deq_accept ? OW'(imin(int'(n_enq), OUT_WIDTH)) : '0;
  assign n_wr = enq_fire ? CW'(n_enq - n_byp) : '0;
  always_comb begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      wr_en[i] = enq_fire && q.enq_valid[i] && int'(off[i]) >= int'(n_byp);
      wr_idx[i] = tail + IW'(off[i]) - IW'(n_byp);
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_WIDTH; i++)
      if (wr_en[i]) mem[wr_idx[i]] <= q.enq_data[i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      head <= head + IW'(n_deq);
      tail <= tail + IW'(n_wr);
      cnt <= cnt + n_wr - n_deq;
    end
  end
  always_comb begin
    for (int j = 0; j < OUT_WIDTH; j++) begin
      q.deq_valid[j] = !flush && j < int'(n_avail);
      q.deq_data[j] = mem[head + IW'(j)];
    end
    if (byp)
      for (int i = 0; i < IN_WIDTH; i++)
        for (int j = 0; j < OUT_WIDTH; j++)
          if (q.enq_valid[i] && int'(off[i]) == j) begin
            q.deq_valid[j] = 1'b1;
            q.deq_data[j] = q.enq_data[i];
          end
  end
endmodule

// File: tb/tb_decoded_mop_queue.sv
// tb_decoded_mop_queue: directed checks of compaction, fill/stall, wrap, flush, bypass and async reset
module tb_decoded_mop_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int total = 0;
  int bad = 0;
  decoded_mop_queue_if bus ();
  decoded_mop_queue dut (.clk(clk), .rst(rst), .flush(flush), .q(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [3:0] v, input logic [63:0] d0,
                         input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3);
    logic [63:0] d [4];
    d = '{d0, d1, d2, d3};
    check({tag, " valid"}, 64'(bus.deq_valid), 64'(v));
    for (int j = 0; j < 4; j++)
      if (v[j]) check($sformatf("%s d%0d", tag, j), bus.deq_data[j], d[j]);
  endtask
  task automatic drive(input logic [3:0] v, input logic [63:0] base, input logic acc, input logic fl);
    bus.enq_valid = v;
    for (int i = 0; i < 4; i++) bus.enq_data[i] = base + 64'(i);
    bus.deq_accept = acc;
    flush = fl;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(4'b0000, 64'h0, 1'b0, 1'b0);
    #12;
    check("rst count", 64'(bus.count), 64'd0);
    check("rst deq_valid", 64'(bus.deq_valid), 64'd0);
    check("rst stall", 64'(bus.enq_stall), 64'd0);
    rst = 1'b0;
    tick;
    // holes compact in lane order
    drive(4'b1011, 64'hA0, 1'b0, 1'b0);
    tick;
    drive(4'b0000, 64'h0, 1'b0, 1'b0);
    check("t1 count", 64'(bus.count), 64'd3);
    chk_out("t1", 4'b0111, 64'hA0, 64'hA1, 64'hA3, 64'h0);
    drive(4'b0000, 64'h0, 1'b1, 1'b0);
    tick;
    drive(4'b0000, 64'h0, 1'b0, 1'b0);
    check("drain count", 64'(bus.count), 64'd0);
    check("drain valid", 64'(bus.deq_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      drive(4'b1111, 64'h100 + 64'(16 * k), 1'b0, 1'b0);
      tick;
      check($sformatf("fill%0d count", k), 64'(bus.count), 64'(4 * (k + 1)));
      if (k == 2) check("fill12 stall", 64'(bus.enq_stall), 64'd0);
    end
    drive(4'b0000, 64'h0, 1'b0, 1'b0);
    check("full stall", 64'(bus.enq_stall), 64'd1);
    drive(4'b1111, 64'h140, 1'b0, 1'b0);
    tick;
    drive(4'b0000, 64'h0, 1'b0, 1'b0);
    check("full ignore count", 64'(bus.count), 64'd16);
    chk_out("full", 4'b1111, 64'h100, 64'h101, 64'h102, 64'h103);
    drive(4'b0000, 64'h0, 1'b1, 1'b0);
    tick;
    check("deq1 count", 64'(bus.count), 64'd12);
    check("deq1 stall", 64'(bus.enq_stall), 64'd0);
    chk_out("deq1", 4'b1111, 64'h110, 64'h111, 64'h112, 64'h113);
    tick;
    check("deq2 count", 64'(bus.count), 64'd8);
    drive(4'b0011, 64'h200, 1'b1, 1'b0);
    tick;
    check("mix1 count", 64'(bus.count), 64'd6);
    chk_out("mix1", 4'b1111, 64'h130, 64'h131, 64'h132, 64'h133);
    drive(4'b1111, 64'h300, 1'b1, 1'b0);
    tick;
    check("mix2 count", 64'(bus.count), 64'd6);
    chk_out("mix2", 4'b1111, 64'h200, 64'h201, 64'h300, 64'h301);
    drive(4'b0000, 64'h0, 1'b1, 1'b0);
    tick;
    chk_out("tail2", 4'b0011, 64'h302, 64'h303, 64'h0, 64'h0);
    tick;
    check("empty count", 64'(bus.count), 64'd0);
    // advance pointers to 14 before the wrap test
    drive(4'b1111, 64'h400, 1'b0, 1'b0);
    tick;
    drive(4'b0001, 64'h410, 1'b0, 1'b0);
    tick;
    drive(4'b0000, 64'h0, 1'b1, 1'b0);
    tick;
    tick;
    check("pre-wrap count", 64'(bus.count), 64'd0);
    tick;
    check("accept empty count", 64'(bus.count), 64'd0);
    check("accept empty valid", 64'(bus.deq_valid), 64'd0);
    drive(4'b1111, 64'h500, 1'b0, 1'b0);
    tick;
    drive(4'b0000, 64'h0, 1'b0, 1'b0);
    check("wrap count", 64'(bus.count), 64'd4);
    chk_out("wrap", 4'b1111, 64'h500, 64'h501, 64'h502, 64'h503);
    drive(4'b1111, 64'h600, 1'b1, 1'b1);
    #1;
    check("flush same valid", 64'(bus.deq_valid), 64'd0);
    tick;
    drive(4'b0000, 64'h0, 1'b0, 1'b0);
    check("flush count", 64'(bus.count), 64'd0);
    check("flush next valid", 64'(bus.deq_valid), 64'd0);
    tick;
    check("flush retain", 64'(bus.count), 64'd0);
    drive(4'b0011, 64'h700, 1'b1, 1'b0);
    #1;
`ifdef RSD_MOP_QUEUE_BYPASS_EN
    chk_out("byp same", 4'b0011, 64'h700, 64'h701, 64'h0, 64'h0);
    tick;
    drive(4'b0000, 64'h0, 1'b0, 1'b0);
    check("byp count", 64'(bus.count), 64'd0);
    check("byp next valid", 64'(bus.deq_valid), 64'd0);
`else
    check("nobyp same valid", 64'(bus.deq_valid), 64'd0);
    tick;
    drive(4'b0000, 64'h0, 1'b0, 1'b0);
    check("nobyp count", 64'(bus.count), 64'd2);
    chk_out("nobyp next", 4'b0011, 64'h700, 64'h701, 64'h0, 64'h0);
`endif
    drive(4'b1111, 64'h800, 1'b0, 1'b0);
    tick;
    drive(4'b0000, 64'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst count", 64'(bus.count), 64'd0);
    check("arst valid", 64'(bus.deq_valid), 64'd0);
    check("arst stall", 64'(bus.enq_stall), 64'd0);
    tick;
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
